// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared types and sizes for the 4:1 mux path arbiter
package mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rtl/mux_arbiter_rr_pick.sv - combinational round-robin winner pick
module rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk from farthest to nearest so the candidate right after last_owner wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last_owner + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin owner arbiter for a shared 4:1 mux path
// Optional forced release after TIMEOUT_CYCLES: define MUX_ARBITER_TIMEOUT_EN.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                timeout
);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_owner_q, last_owner_d;

    logic                pick_valid;
    logic [SEL_W-1:0]    pick_idx;
    logic                grant_ev;
    logic                tmo_ev;
    logic                tmo_hit;

    rr_pick u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        grant_ev     = 1'b0;
        tmo_ev       = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    state_d           = GRANT;
                    grant_ev          = 1'b1;
                end
            end
            GRANT: begin
                // A plain release takes precedence over a coincident timeout.
                if (!req[sel_q] || tmo_hit) begin
                    grant_d      = '0;
                    last_owner_d = sel_q;
                    state_d      = RELEASE;
                    tmo_ev       = req[sel_q];
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            last_owner_q <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
        end
    end

`ifdef MUX_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign tmo_hit = (cnt_q == TMO_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = tmo_ev;
        if (grant_ev) begin
            cnt_d = '0;
        end else if (state_q == GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic [7:0] tmo_unused;
    logic       tmo_ev_unused;

    assign tmo_hit       = 1'b0;
    assign tmo_unused    = 8'(TIMEOUT_CYCLES);
    assign tmo_ev_unused = tmo_ev | grant_ev;
    assign timeout       = 1'b0;
`endif

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    mux_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic t);
        chk({tag, "_grant"},   8'(grant),   8'(g));
        chk({tag, "_sel"},     8'(sel),     8'(s));
        chk({tag, "_busy"},    8'(busy),    8'(b));
        chk({tag, "_timeout"}, 8'(timeout), 8'(t));
    endtask

    initial begin
        int order [5];
        logic [3:0] exp_g;
        checks = 0;
        errors = 0;
        order  = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req = 4'b0000;
        #3;
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // first grant, one cycle latency
        req = 4'b0001;
        tick();
        chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_all("first_release", 4'b0000, 2'd0, 1'b1, 1'b0);
        tick();
        chk_all("first_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // restart priority from req[0]
        #2 rst = 1'b1;
        #2 rst = 1'b0;

        // round robin with all requesters active
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << order[i];
            tick();
            chk_all("rr_grant", exp_g, 2'(order[i]), 1'b1, 1'b0);
            tick();
            chk("rr_hold1", 8'(grant), 8'(exp_g));
            tick();
            chk("rr_hold2", 8'(grant), 8'(exp_g));
            req[order[i]] = 1'b0;
            tick();
            chk_all("rr_release", 4'b0000, 2'(order[i]), 1'b1, 1'b0);
            req = 4'b1111;
            if (i == 4) req = 4'b0000;
            tick();
            chk_all("rr_idle", 4'b0000, 2'(order[i]), 1'b0, 1'b0);
        end

        // no preemption during tenure
        req = 4'b0100;
        tick();
        chk_all("np_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0101;
        tick();
        chk("np_hold1", 8'(grant), 8'h4);
        tick();
        chk("np_hold2", 8'(grant), 8'h4);
        req = 4'b0001;
        tick();
        chk_all("np_release", 4'b0000, 2'd2, 1'b1, 1'b0);
        tick();
        chk_all("np_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        chk_all("np_next", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();

        // long hold by requester 1
        req = 4'b0010;
        tick();
        chk_all("tmo_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef MUX_ARBITER_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk_all("tmo_last_cycle", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        chk_all("tmo_pulse", 4'b0000, 2'd1, 1'b1, 1'b1);
        tick();
        chk_all("tmo_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("tmo_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk_all("tmo_coincide", 4'b0000, 2'd1, 1'b1, 1'b0);
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("unbounded_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk_all("hold_release", 4'b0000, 2'd1, 1'b1, 1'b0);
        tick();
`endif

        // reset in the middle of a grant
        req = 4'b1000;
        tick();
        chk_all("pre_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b1001;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("post_rst_pick", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();

        // a request withdrawn before any edge samples it gets nothing
        #2 req = 4'b0100;
        #2 req = 4'b0000;
        tick();
        chk_all("withdrawn", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL be the maximum consecutive GRANT-state cycles per owner; legal range 2..255.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-004 Port req, input, 4, SHALL carry the per-requester request for the shared 4:1 mux path; req[i] is held high for the whole ownership period.
REQ-005 Port grant, output, 4, SHALL be the registered one-hot or zero grant vector.
REQ-006 Port sel, output, 2, SHALL be the registered mux select: sel[1] drives S1 and sel[0] drives S0; the value equals the granted index.
REQ-007 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.
REQ-008 Port timeout, output, 1, SHALL be a one-cycle pulse on a forced release.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-010 In IDLE with req != 0, the FSM SHALL register the winner on the next edge: grant = onehot(w), sel = w, state -> GRANT. Request-to-grant latency is 1 cycle.
REQ-011 In IDLE with req == 0, the FSM SHALL stay in IDLE with grant = 0 and sel holding its last value.
REQ-012 Winner selection SHALL be round-robin: search order starts at (last_owner+1) mod 4, ascending with wrap 3->0.
REQ-013 In GRANT, while req[owner] = 1 and no timeout fires, grant and sel SHALL be held unchanged; requests from other requesters SHALL NOT preempt.
REQ-014 In GRANT, when req[owner] = 0 is sampled, the next edge SHALL clear grant, update last_owner to owner, and move to RELEASE.
REQ-015 RELEASE SHALL last exactly 1 cycle with grant = 0 and sel held, for mux settle. It then moves to IDLE, so the next grant occurs no earlier than 2 cycles after release.
REQ-016 Simultaneous requests SHALL be resolved solely by REQ-012; at most one grant bit is ever high.
REQ-017 A requester whose req drops in IDLE before being granted SHALL receive no grant.

Reset
REQ-018 With rst high, the block SHALL immediately force state = IDLE, grant = 0, sel = 0, busy = 0, timeout = 0, last_owner = 3 (so req[0] has first priority) and the timeout counter = 0.
REQ-019 Reset asserted mid-GRANT SHALL drop grant asynchronously; no RELEASE cycle and no timeout pulse SHALL occur.
REQ-020 After rst deasserts, the first arbitration SHALL occur on the first clk edge that samples req != 0.

Configuration
REQ-021 Macro MUX_ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle. When the counter equals TIMEOUT_CYCLES-1 with req[owner] still high, the next edge SHALL force the REQ-014 transition and pulse timeout for that one cycle.
REQ-022 Macro MUX_ARBITER_TIMEOUT_EN undefined: no counter SHALL be built, timeout SHALL be tied to 0, and ownership SHALL be unbounded.
REQ-023 If release (req[owner] = 0) and timeout coincide, the event SHALL be treated as a normal release with timeout = 0.

Structure
REQ-024 Package mux_arbiter_pkg SHALL hold the state enum (IDLE, GRANT, RELEASE), NUM_REQ = 4 and SEL_W = 2.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req[3:0] and last_owner[1:0] and outputs valid and idx[1:0]. The FSM, registers and counter SHALL live in mux_arbiter.

Verification
REQ-026 Reset, then req = 0001 -> grant = 0001 and sel = 00 one cycle later; busy = 1.
REQ-027 req = 1111 held, each owner releasing after 3 cycles -> grant order 0,1,2,3,0 with a single zero-grant RELEASE cycle between each.
REQ-028 Owner 2 granted, req[0] asserted mid-tenure -> grant stays 0100 until req[2] drops, then 0001 two cycles later.
REQ-029 MUX_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, req[1] held high -> grant drops after 4 GRANT cycles, timeout pulses once, and req[1] is re-granted after RELEASE and IDLE if no other requester is pending.
REQ-030 rst pulsed while grant = 1000 -> grant = 0 and sel = 00 immediately, timeout = 0. With req = 1001 after reset, req[0] wins first.
